dma_desc_credit_arb: RTL and testbench
======================================

DMA_DESC_CREDIT_ARB -- requirements
Module: dma_desc_credit_arb

Interface
REQ-001 Parameter PORTS, default 2: number of descriptor requester ports (2..16).
REQ-002 Parameter DMA_ADDR_WIDTH, default 64: DMA address width.
REQ-003 Parameter RAM_ADDR_WIDTH, default 16: RAM address width.
REQ-004 Parameter LEN_WIDTH, default 16: length field width.
REQ-005 Parameter S_TAG_WIDTH, default 8: requester tag width.
REQ-006 Parameter M_TAG_WIDTH, default S_TAG_WIDTH+$clog2(PORTS): output tag width; smaller values SHALL stop elaboration with $error.
REQ-007 Parameter MAX_OUTSTANDING, default 8: per-port limit on in-flight descriptors (1..255).
REQ-008 Clocking: one clock; reset is asynchronous and active-low.
REQ-009 clk  input  1  clock; all state on rising edge.
REQ-010 rst_n  input  1  asynchronous active-low reset.
REQ-011 s_axis_desc_{dma_addr,ram_addr,len,tag}  input  PORTS*{DMA_ADDR_WIDTH,RAM_ADDR_WIDTH,LEN_WIDTH,S_TAG_WIDTH}  per-port descriptor fields.
REQ-012 s_axis_desc_valid  input  PORTS, and s_axis_desc_ready  output  PORTS  per-port handshake.
REQ-013 m_axis_desc_{dma_addr,ram_addr,len,tag}  output  {DMA_ADDR_WIDTH,RAM_ADDR_WIDTH,LEN_WIDTH,M_TAG_WIDTH}  issued descriptor.
REQ-014 m_axis_desc_valid  output  1, and m_axis_desc_ready  input  1  output handshake.
REQ-015 s_axis_desc_status_{tag,error,valid}  input  {M_TAG_WIDTH,4,1}  completion from DMA interface.
REQ-016 m_axis_desc_status_{tag,error}  output  {PORTS*S_TAG_WIDTH,PORTS*4}, and m_axis_desc_status_valid  output  PORTS  routed completions.
REQ-017 port_busy  output  PORTS  bit p high while port p outstanding count is nonzero.
REQ-018 status_underflow  output  1  sticky flag, set on a completion for a port whose count is zero.

Function
REQ-019 Port p is eligible when s_axis_desc_valid[p] is high and count[p] < MAX_OUTSTANDING.
REQ-020 Arbitration is round-robin: search starts at (last_grant+1) mod PORTS, and the first eligible port wins.
REQ-021 Output register is free when m_axis_desc_valid=0 or m_axis_desc_ready=1.
REQ-022 When free and some port is eligible:
  - s_axis_desc_ready is asserted combinationally for the winner only, one-hot.
  - Winner fields load into the output register at the edge; tag = {port index, s_tag}.
  - m_axis_desc_valid is set; last_grant is updated.
REQ-023 Input-to-output latency is 1 cycle; sustained throughput is one descriptor per cycle while m_axis_desc_ready=1.
REQ-024 When free and no port is eligible, m_axis_desc_valid clears; the registered output holds its data while valid and not ready.
REQ-025 s_axis_desc_ready is low for every port while the output register is not free or the port is not eligible.
REQ-026 count[p] increments on an accepted handshake on port p.
REQ-027 count[p] decrements on s_axis_desc_status_valid with tag[M_TAG_WIDTH-1 -: $clog2(PORTS)]==p.
REQ-028 Simultaneous increment and decrement on the same port leaves count unchanged.
REQ-029 A decrement with count 0 leaves count at 0 and sets status_underflow; the completion is still forwarded.
REQ-030 Status routing is registered with 1-cycle latency:
  - m_axis_desc_status_valid is one-hot at the decoded port.
  - tag (low S_TAG_WIDTH bits) and error are replicated to all ports.
REQ-031 Status has no backpressure; a completion is accepted every cycle.
REQ-032 Counter width is $clog2(MAX_OUTSTANDING+1).
REQ-033 A count never exceeds MAX_OUTSTANDING.

Reset
REQ-034 On rst_n low, the block asynchronously clears:
  - m_axis_desc_valid, m_axis_desc_status_valid, s_axis_desc_ready.
  - all counts, status_underflow, port_busy.
  - last_grant to PORTS-1, so port 0 has first priority.
REQ-035 Data registers reset to 0.
REQ-036 Reset mid-transfer discards the held descriptor and all outstanding state.
REQ-037 The first grant is possible in the first cycle after rst_n deasserts.

Verification
REQ-038 Ports 0 and 1 both valid continuously, m_axis_desc_ready=1 -> output tags alternate port 0,1,0,1; first valid descriptor appears 1 cycle after reset release.
REQ-039 MAX_OUTSTANDING=2, port 0 only valid, no status -> exactly 2 descriptors issue, then s_axis_desc_ready[0]=0 and port_busy[0]=1; one status with tag {0,x} restores ready on the next cycle.
REQ-040 m_axis_desc_ready held low for 3 cycles with a descriptor pending -> output fields are stable, no s_axis_desc_ready asserted; the next edge after ready rises accepts a new descriptor.
REQ-041 Status tag {1,0x5A}, error 4'h3 -> next cycle m_axis_desc_status_valid=2'b10, port 1 tag 0x5A, error 3; count[1] is decremented.
REQ-042 Accept on port 1 in the same cycle as a status for port 1 -> count[1] unchanged. Status for a port at count 0 -> status_underflow=1 until reset.
REQ-043 rst_n asserted while output valid and counts nonzero -> all outputs are 0 immediately; after release, port 0 is granted first.

Source files
------------

// File: rtl/dma_desc_credit_arb.sv
// Round-robin descriptor arbiter with per-port credit limits on in-flight descriptors.
// Completions are routed back to the issuing port by the port index held in the tag MSBs.
module dma_desc_credit_arb #(
  parameter int unsigned PORTS           = 2,
  parameter int unsigned DMA_ADDR_WIDTH  = 64,
  parameter int unsigned RAM_ADDR_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned S_TAG_WIDTH     = 8,
  parameter int unsigned M_TAG_WIDTH     = S_TAG_WIDTH + $clog2(PORTS),
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,

  input  logic [PORTS*DMA_ADDR_WIDTH-1:0]  s_axis_desc_dma_addr,
  input  logic [PORTS*RAM_ADDR_WIDTH-1:0]  s_axis_desc_ram_addr,
  input  logic [PORTS*LEN_WIDTH-1:0]       s_axis_desc_len,
  input  logic [PORTS*S_TAG_WIDTH-1:0]     s_axis_desc_tag,
  input  logic [PORTS-1:0]                 s_axis_desc_valid,
  output logic [PORTS-1:0]                 s_axis_desc_ready,

  output logic [DMA_ADDR_WIDTH-1:0]        m_axis_desc_dma_addr,
  output logic [RAM_ADDR_WIDTH-1:0]        m_axis_desc_ram_addr,
  output logic [LEN_WIDTH-1:0]             m_axis_desc_len,
  output logic [M_TAG_WIDTH-1:0]           m_axis_desc_tag,
  output logic                             m_axis_desc_valid,
  input  logic                             m_axis_desc_ready,

  input  logic [M_TAG_WIDTH-1:0]           s_axis_desc_status_tag,
  input  logic [3:0]                       s_axis_desc_status_error,
  input  logic                             s_axis_desc_status_valid,

  output logic [PORTS*S_TAG_WIDTH-1:0]     m_axis_desc_status_tag,
  output logic [PORTS*4-1:0]               m_axis_desc_status_error,
  output logic [PORTS-1:0]                 m_axis_desc_status_valid,

  output logic [PORTS-1:0]                 port_busy,
  output logic                             status_underflow
);

  localparam int unsigned PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);

  if (M_TAG_WIDTH < S_TAG_WIDTH + $clog2(PORTS)) begin : g_bad_m_tag
    $error("M_TAG_WIDTH must be at least S_TAG_WIDTH + clog2(PORTS)");
  end
  if (PORTS < 2 || PORTS > 16) begin : g_bad_ports
    $error("PORTS must be in 2..16");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max
    $error("MAX_OUTSTANDING must be in 1..255");
  end

  typedef struct packed {
    logic [DMA_ADDR_WIDTH-1:0] dma_addr;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [LEN_WIDTH-1:0]      len;
    logic [M_TAG_WIDTH-1:0]    tag;
  } desc_t;

  desc_t                desc_q, desc_d, win_desc;
  logic                 m_valid_q, m_valid_d;
  logic [PORT_W-1:0]    last_grant_q, last_grant_d;
  logic [CNT_W-1:0]     count_q [PORTS];
  logic [CNT_W-1:0]     count_d [PORTS];
  logic [PORTS-1:0]     busy_q, busy_d;
  logic                 underflow_q, underflow_d;
  logic [PORTS-1:0]     st_valid_q, st_valid_d;
  logic [S_TAG_WIDTH-1:0] st_tag_q, st_tag_d;
  logic [3:0]           st_err_q, st_err_d;

  logic [PORTS-1:0]     eligible;
  logic [PORTS-1:0]     grant_oh;
  logic [PORTS-1:0]     inc;
  logic [PORTS-1:0]     dec;
  logic                 grant_found;
  logic [PORT_W-1:0]    grant_idx;
  logic                 out_free;
  logic [PORT_W-1:0]    st_port;
  int unsigned          cand;

  // A port may compete only while it has credit left.
  always_comb begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      eligible[p] = s_axis_desc_valid[p] && (count_q[p] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Round-robin search starting just after the last granted port.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      cand = (32'(last_grant_q) + i) % PORTS;
      if (!grant_found && eligible[cand[PORT_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[PORT_W-1:0];
      end
    end
  end

  assign out_free = !m_valid_q || m_axis_desc_ready;

  always_comb begin
    grant_oh = '0;
    if (rst_n && out_free && grant_found) begin
      grant_oh = PORTS'(1) << grant_idx;
    end
  end

  assign s_axis_desc_ready = grant_oh;
  assign inc               = grant_oh & s_axis_desc_valid;

  // Winner field mux; the port index is stamped into the tag MSBs.
  always_comb begin
    win_desc = '0;
    for (int unsigned p = 0; p < PORTS; p++) begin
      if (grant_idx == PORT_W'(p)) begin
        win_desc.dma_addr = s_axis_desc_dma_addr[p*DMA_ADDR_WIDTH +: DMA_ADDR_WIDTH];
        win_desc.ram_addr = s_axis_desc_ram_addr[p*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH];
        win_desc.len      = s_axis_desc_len[p*LEN_WIDTH +: LEN_WIDTH];
        win_desc.tag[S_TAG_WIDTH-1:0] = s_axis_desc_tag[p*S_TAG_WIDTH +: S_TAG_WIDTH];
      end
    end
    win_desc.tag[M_TAG_WIDTH-1 -: PORT_W] = grant_idx;
  end

  // Output register: load on grant, drop valid when free with nothing to send.
  always_comb begin
    m_valid_d    = m_valid_q;
    desc_d       = desc_q;
    last_grant_d = last_grant_q;
    if (out_free) begin
      m_valid_d = grant_found;
      if (grant_found) begin
        desc_d       = win_desc;
        last_grant_d = grant_idx;
      end
    end
  end

  assign st_port = s_axis_desc_status_tag[M_TAG_WIDTH-1 -: PORT_W];

  always_comb begin
    for (int unsigned p = 0; p < PORTS; p++) begin
      dec[p] = s_axis_desc_status_valid && (st_port == PORT_W'(p));
    end
  end

  // Completion routing: one-hot valid, tag and error fanned out to every port.
  always_comb begin
    st_valid_d = dec;
    st_tag_d   = st_tag_q;
    st_err_d   = st_err_q;
    if (s_axis_desc_status_valid) begin
      st_tag_d = s_axis_desc_status_tag[S_TAG_WIDTH-1:0];
      st_err_d = s_axis_desc_status_error;
    end
  end

  // Credit counters; a completion against an empty counter is flagged, not applied.
  always_comb begin
    underflow_d = underflow_q;
    for (int unsigned p = 0; p < PORTS; p++) begin
      count_d[p] = count_q[p];
      if (inc[p] && !dec[p]) begin
        count_d[p] = count_q[p] + CNT_W'(1);
      end else if (!inc[p] && dec[p] && (count_q[p] != '0)) begin
        count_d[p] = count_q[p] - CNT_W'(1);
      end
      if (dec[p] && (count_q[p] == '0)) begin
        underflow_d = 1'b1;
      end
      busy_d[p] = (count_d[p] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desc_q       <= '0;
      m_valid_q    <= 1'b0;
      last_grant_q <= PORT_W'(PORTS - 1);
      busy_q       <= '0;
      underflow_q  <= 1'b0;
      st_valid_q   <= '0;
      st_tag_q     <= '0;
      st_err_q     <= '0;
      for (int unsigned p = 0; p < PORTS; p++) begin
        count_q[p] <= '0;
      end
    end else begin
      desc_q       <= desc_d;
      m_valid_q    <= m_valid_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      underflow_q  <= underflow_d;
      st_valid_q   <= st_valid_d;
      st_tag_q     <= st_tag_d;
      st_err_q     <= st_err_d;
      for (int unsigned p = 0; p < PORTS; p++) begin
        count_q[p] <= count_d[p];
      end
    end
  end

  assign m_axis_desc_dma_addr     = desc_q.dma_addr;
  assign m_axis_desc_ram_addr     = desc_q.ram_addr;
  assign m_axis_desc_len          = desc_q.len;
  assign m_axis_desc_tag          = desc_q.tag;
  assign m_axis_desc_valid        = m_valid_q;
  assign m_axis_desc_status_valid = st_valid_q;
  assign m_axis_desc_status_tag   = {PORTS{st_tag_q}};
  assign m_axis_desc_status_error = {PORTS{st_err_q}};
  assign port_busy                = busy_q;
  assign status_underflow         = underflow_q;

endmodule

// File: tb/tb_dma_desc_credit_arb.sv
// Randomized bench for dma_desc_credit_arb against a transaction-level reference model,
// plus directed sequences for alternation, credit exhaustion, backpressure and reset.
module tb_dma_desc_credit_arb;

  localparam int unsigned P   = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned RW  = 16;
  localparam int unsigned LW  = 16;
  localparam int unsigned SW  = 8;
  localparam int unsigned PW  = 2;
  localparam int unsigned MW  = SW + PW;
  localparam int unsigned MAX = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [P*DW-1:0] s_dma;
  logic [P*RW-1:0] s_ram;
  logic [P*LW-1:0] s_len;
  logic [P*SW-1:0] s_tag;
  logic [P-1:0]    s_valid;
  logic [P-1:0]    s_ready;
  logic [DW-1:0]   m_dma;
  logic [RW-1:0]   m_ram;
  logic [LW-1:0]   m_len;
  logic [MW-1:0]   m_tag;
  logic            m_valid;
  logic            m_ready;
  logic [MW-1:0]   st_tag;
  logic [3:0]      st_err;
  logic            st_valid;
  logic [P*SW-1:0] ms_tag;
  logic [P*4-1:0]  ms_err;
  logic [P-1:0]    ms_valid;
  logic [P-1:0]    busy;
  logic            underflow;

  dma_desc_credit_arb #(
    .PORTS(P), .DMA_ADDR_WIDTH(DW), .RAM_ADDR_WIDTH(RW), .LEN_WIDTH(LW),
    .S_TAG_WIDTH(SW), .M_TAG_WIDTH(MW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_desc_dma_addr(s_dma), .s_axis_desc_ram_addr(s_ram),
    .s_axis_desc_len(s_len), .s_axis_desc_tag(s_tag),
    .s_axis_desc_valid(s_valid), .s_axis_desc_ready(s_ready),
    .m_axis_desc_dma_addr(m_dma), .m_axis_desc_ram_addr(m_ram),
    .m_axis_desc_len(m_len), .m_axis_desc_tag(m_tag),
    .m_axis_desc_valid(m_valid), .m_axis_desc_ready(m_ready),
    .s_axis_desc_status_tag(st_tag), .s_axis_desc_status_error(st_err),
    .s_axis_desc_status_valid(st_valid),
    .m_axis_desc_status_tag(ms_tag), .m_axis_desc_status_error(ms_err),
    .m_axis_desc_status_valid(ms_valid),
    .port_busy(busy), .status_underflow(underflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int            mc [P];
  int            mlg;
  bit            mv;
  logic [DW-1:0] md;
  logic [RW-1:0] mr;
  logic [LW-1:0] ml;
  logic [MW-1:0] mt;
  logic [P-1:0]  msv;
  logic [SW-1:0] mst;
  logic [3:0]    mse;
  bit            muf;

  logic [DW-1:0] hold_dma;
  logic [MW-1:0] hold_tag;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int i = 1; i <= int'(P); i++) begin
      int c;
      c = (mlg + i) % int'(P);
      if (s_valid[c] && mc[c] < int'(MAX)) return c;
    end
    return -1;
  endfunction

  function automatic logic [P-1:0] exp_ready();
    int w;
    w = pick();
    if ((!mv || m_ready) && w >= 0) return P'(1) << w;
    return '0;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < int'(P); p++) mc[p] = 0;
    mlg = P - 1;
    mv  = 0;
    md  = '0; mr = '0; ml = '0; mt = '0;
    msv = '0; mst = '0; mse = '0;
    muf = 0;
  endtask

  task automatic model_edge();
    int  w;
    int  sp;
    bit  free;
    free = !mv || m_ready;
    w    = free ? pick() : -1;
    if (free) begin
      if (w >= 0) begin
        mv  = 1;
        md  = s_dma[w*DW +: DW];
        mr  = s_ram[w*RW +: RW];
        ml  = s_len[w*LW +: LW];
        mt  = {PW'(w), s_tag[w*SW +: SW]};
        mlg = w;
      end else begin
        mv = 0;
      end
    end
    sp  = st_valid ? int'(st_tag[MW-1 -: PW]) : -1;
    msv = '0;
    if (st_valid) begin
      mst = st_tag[SW-1:0];
      mse = st_err;
      if (sp < int'(P)) msv[sp] = 1'b1;
    end
    for (int p = 0; p < int'(P); p++) begin
      bit inc;
      bit dec;
      inc = (w == p);
      dec = (sp == p);
      if (dec && mc[p] == 0) muf = 1;
      if (inc && !dec) mc[p]++;
      else if (dec && !inc && mc[p] > 0) mc[p]--;
    end
  endtask

  task automatic check_outputs();
    logic [P-1:0] eb;
    for (int p = 0; p < int'(P); p++) eb[p] = (mc[p] != 0);
    chk("m_valid", m_valid, mv);
    chk("m_dma", m_dma, md);
    chk("m_ram", m_ram, mr);
    chk("m_len", m_len, ml);
    chk("m_tag", m_tag, mt);
    chk("st_valid", ms_valid, msv);
    for (int p = 0; p < int'(P); p++) begin
      chk("st_tag", ms_tag[p*SW +: SW], mst);
      chk("st_err", ms_err[p*4 +: 4], mse);
    end
    chk("port_busy", busy, eb);
    chk("underflow", underflow, muf);
  endtask

  // One clock: check the combinational grant, advance the model, check registers.
  task automatic cycle();
    #1;
    chk("s_ready", s_ready, exp_ready());
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic check_zero_outputs();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_st_valid", ms_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_m_tag", m_tag, 0);
    chk("rst_m_dma", m_dma, 0);
    chk("rst_st_tag", ms_tag, 0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check_zero_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_data();
    for (int p = 0; p < int'(P); p++) begin
      s_dma[p*DW +: DW] = $urandom;
      s_ram[p*RW +: RW] = RW'($urandom);
      s_len[p*LW +: LW] = LW'($urandom);
      s_tag[p*SW +: SW] = SW'($urandom);
    end
  endtask

  task automatic send_status(input int port, input logic [SW-1:0] t, input logic [3:0] e);
    st_valid = 1'b1;
    st_tag   = {PW'(port), t};
    st_err   = e;
  endtask

  initial begin
    s_valid = '0; m_ready = 1'b1;
    st_valid = 1'b0; st_tag = '0; st_err = '0;
    rand_data();
    model_reset();
    #2;
    apply_reset();

    // Ports 0 and 1 compete: grants alternate until both run out of credit
    s_valid = 3'b011;
    cycle();
    chk("alt_first_valid", m_valid, 1);
    chk("alt_port_0a", m_tag[MW-1 -: PW], 0);
    cycle();
    chk("alt_port_1a", m_tag[MW-1 -: PW], 1);
    cycle();
    chk("alt_port_0b", m_tag[MW-1 -: PW], 0);
    cycle();
    chk("alt_port_1b", m_tag[MW-1 -: PW], 1);
    cycle();
    chk("credit_exhausted_valid", m_valid, 0);
    chk("credit_busy", busy, 3'b011);
    chk("credit_ready_low", s_ready, 3'b000);

    // One completion for port 0 restores its credit next cycle
    send_status(0, 8'h11, 4'h0);
    cycle();
    st_valid = 1'b0;
    #1;
    chk("credit_restored", s_ready, 3'b001);
    cycle();

    // Completion routing to port 1
    send_status(1, 8'h5A, 4'h3);
    cycle();
    chk("route_valid", ms_valid, 3'b010);
    chk("route_tag_p1", ms_tag[SW +: SW], 8'h5A);
    chk("route_err_p1", ms_err[4 +: 4], 4'h3);
    st_valid = 1'b0;

    // Accept and complete on port 1 in the same cycle
    s_valid = 3'b010;
    send_status(1, 8'h22, 4'h1);
    cycle();
    chk("inc_dec_busy", busy, 3'b011);

    // Completion for an idle port raises the sticky underflow
    s_valid = 3'b000;
    send_status(2, 8'h33, 4'h2);
    cycle();
    chk("underflow_set", underflow, 1);
    st_valid = 1'b0;
    cycle();
    cycle();
    chk("underflow_sticky", underflow, 1);

    // Reset with a descriptor held and credits in use
    s_valid = 3'b111;
    rand_data();
    cycle();
    chk("pre_rst_valid", m_valid, 1);
    apply_reset();

    // First grant after reset goes to port 0, then hold under backpressure
    m_ready = 1'b0;
    cycle();
    chk("post_rst_port0", m_tag[MW-1 -: PW], 0);
    hold_dma = m_dma;
    hold_tag = m_tag;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      cycle();
      chk("bp_dma_stable", m_dma, hold_dma);
      chk("bp_tag_stable", m_tag, hold_tag);
    end
    m_ready = 1'b1;
    cycle();
    chk("bp_release_port1", m_tag[MW-1 -: PW], 1);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      rand_data();
      s_valid = P'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) send_status($urandom_range(0, 3), SW'($urandom), 4'($urandom));
      else st_valid = 1'b0;
      if ($urandom_range(0, 499) == 0) apply_reset();
      else cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
